// File: rtl/hevc_ref_row_feeder_pkg.sv
// Shared types and helpers for the reference-row feeder.
// Row geometry, FSM states and the row alignment function.
package hevc_ref_row_feeder_pkg;

  localparam int PIX_W    = 8;
  localparam int WORD_PIX = 16;
  localparam int ROW_PIX  = 15;
  localparam int MAX_ROWS = 15;

  localparam int WORD_W = PIX_W * WORD_PIX;
  localparam int ROW_W  = PIX_W * ROW_PIX;
  localparam int IDX_W  = 4;
  localparam int ENT_W  = ROW_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [ROW_W-1:0] row;
  } row_ent_t;

  function automatic logic [ROW_W-1:0] align_row(
    input logic [WORD_W-1:0] lo,
    input logic [WORD_W-1:0] hi,
    input logic [3:0]        x
  );
    logic [2*WORD_W-1:0] w;
    w = {hi, lo} >> {x, 3'b000};
    return w[ROW_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] clamp_rows(
    input logic [4:0] n
  );
    return (n > 5'(MAX_ROWS)) ? IDX_W'(MAX_ROWS)
                              : n[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/hevc_ref_row_feeder_if.sv
// Memory read ports and in_row stream of the feeder.
// master = feeder side, slave = memory/interpolator side.
interface hevc_ref_row_feeder_if #(
  parameter int AW = 16
);
  import hevc_ref_row_feeder_pkg::*;

  logic              mem_rd_en;
  logic [AW-1:0]     mem_addr_lo;
  logic [AW-1:0]     mem_addr_hi;
  logic [WORD_W-1:0] mem_rdata_lo;
  logic [WORD_W-1:0] mem_rdata_hi;
  logic [ROW_W-1:0]  in_row;
  logic              row_valid;
  logic              row_ready;
  logic [IDX_W-1:0]  row_idx;

  modport master (
    output mem_rd_en,
    output mem_addr_lo,
    output mem_addr_hi,
    input  mem_rdata_lo,
    input  mem_rdata_hi,
    output in_row,
    output row_valid,
    input  row_ready,
    output row_idx
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr_lo,
    input  mem_addr_hi,
    output mem_rdata_lo,
    output mem_rdata_hi,
    input  in_row,
    input  row_valid,
    output row_ready,
    input  row_idx
  );

endinterface

// File: rtl/hevc_ref_row_feeder_row_fifo2.sv
// Two-entry synchronous FIFO holding aligned rows and their index.
// Push on a full FIFO is accepted only together with a pop.
module row_fifo2 #(
  parameter int W = 124
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic [1:0]   o_count,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop & (r_cnt != 2'd0);
  assign w_push = i_push & ((r_cnt != 2'd2) | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      r_cnt <= r_cnt + {1'b0, w_push}
                     - {1'b0, w_pop};
    end
  end

  assign o_dout  = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);

endmodule

// File: rtl/hevc_ref_row_feeder.sv
// Fetches up to 15 reference rows, aligns each to x_off and
// streams them to the interpolator with valid/ready.
module hevc_ref_row_feeder
  import hevc_ref_row_feeder_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] stride,
  input  logic [3:0]    x_off,
  input  logic [4:0]    num_rows,
  output logic          busy,
  output logic          done,
  hevc_ref_row_feeder_if.master bus
);

  state_t           r_state;
  state_t           w_next;
  logic [AW-1:0]    r_addr;
  logic [AW-1:0]    r_stride;
  logic [3:0]       r_xoff;
  logic [IDX_W-1:0] r_rows;
  logic [IDX_W-1:0] r_issued;
  logic [IDX_W-1:0] r_accepted;
  logic             r_pend;
  logic [IDX_W-1:0] r_pend_idx;
  logic             r_zero_done;

  logic [IDX_W-1:0] w_rows_in;
  logic             w_start;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic             w_done;
  logic [2:0]       w_occ;
  logic [1:0]       w_cnt;
  logic             w_full;
  logic             w_empty;
  row_ent_t         w_din;
  row_ent_t         w_head;

  assign w_rows_in = clamp_rows(num_rows);
  assign w_start   = start & (r_state == IDLE);
  assign w_pop     = bus.row_valid & bus.row_ready;

  // Rows buffered or in flight after this cycle's pop.
  assign w_occ   = {1'b0, w_cnt} + {2'b0, r_pend}
                 - {2'b0, w_pop};
  assign w_issue = (r_state == RUN)
                 & (r_issued != r_rows)
                 & (w_occ < 3'd2);

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start && w_rows_in != '0) begin
          w_next = RUN;
        end
      end
      RUN: begin
        if (r_issued == r_rows) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (r_accepted == r_rows) begin
          w_next = IDLE;
          w_done = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_stride    <= '0;
      r_xoff      <= '0;
      r_rows      <= '0;
      r_issued    <= '0;
      r_accepted  <= '0;
      r_pend      <= 1'b0;
      r_pend_idx  <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_zero_done <= w_start & (w_rows_in == '0);
      r_pend      <= w_issue;
      if (w_issue) begin
        r_pend_idx <= r_issued;
      end
      if (w_start) begin
        r_addr     <= base_addr;
        r_stride   <= stride;
        r_xoff     <= x_off;
        r_rows     <= w_rows_in;
        r_issued   <= '0;
        r_accepted <= '0;
      end else begin
        if (w_issue) begin
          r_addr   <= r_addr + r_stride;
          r_issued <= r_issued + 1'b1;
        end
        if (w_pop) begin
          r_accepted <= r_accepted + 1'b1;
        end
      end
    end
  end

  assign w_din.idx = r_pend_idx;
  assign w_din.row = align_row(bus.mem_rdata_lo,
                               bus.mem_rdata_hi,
                               r_xoff);
  assign w_push    = r_pend & (~w_full | w_pop);

  row_fifo2 #(
    .W (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (w_cnt),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign busy = (r_state != IDLE);
  assign done = w_done | r_zero_done;

  // Addresses read as zero whenever no read is issued.
  assign bus.mem_rd_en   = w_issue;
  assign bus.mem_addr_lo = w_issue ? r_addr : '0;
  assign bus.mem_addr_hi = w_issue ? r_addr + AW'(1)
                                   : '0;
  assign bus.in_row      = w_head.row;
  assign bus.row_idx     = w_head.idx;
  assign bus.row_valid   = ~w_empty;

endmodule

// File: tb/tb_hevc_ref_row_feeder.sv
// Bench for hevc_ref_row_feeder: memory model, row scoreboard
// and directed plus randomized windows.
module tb_hevc_ref_row_feeder;
  import hevc_ref_row_feeder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] stride;
  logic [3:0]  x_off;
  logic [4:0]  num_rows;
  logic        busy;
  logic        done;

  hevc_ref_row_feeder_if #(.AW(16)) bus();

  hevc_ref_row_feeder #(.AW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .stride    (stride),
    .x_off     (x_off),
    .num_rows  (num_rows),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [119:0] row;
    logic [3:0]   idx;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  bit          ramp = 0;
  int unsigned seed;
  exp_t        exp_q[$];
  logic [15:0] addr_q[$];
  int          issued;
  int          accepted;
  bit          prev_stall = 0;
  logic [119:0] prev_row;
  logic [3:0]  prev_idx;
  logic [119:0] first_row;
  bit          first_seen;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, expv);
    end
  endtask

  // Pixel p of the memory word at address a.
  function automatic logic [7:0] px(input logic [15:0] a,
                                    input int p,
                                    input bit is_hi);
    if (ramp) return is_hi ? 8'(16 + p) : 8'(p);
    return 8'((a * 37) ^ (a >> 5) ^ (p * 113) ^ seed);
  endfunction

  function automatic logic [127:0] word(input logic [15:0] a,
                                        input bit is_hi);
    logic [127:0] w;
    for (int p = 0; p < 16; p++) w[p*8 +: 8] = px(a, p, is_hi);
    return w;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rdata_lo <= word(bus.mem_addr_lo, 1'b0);
      bus.mem_rdata_hi <= word(bus.mem_addr_hi, 1'b1);
    end else begin
      bus.mem_rdata_lo <= {4{$urandom}};
      bus.mem_rdata_hi <= {4{$urandom}};
    end
  end

  // Expected window: row r at base + r*stride, pixel k taken
  // from pixel x+k of the two-word concatenation.
  task automatic model(input logic [15:0] b, input logic [15:0] s,
                       input logic [3:0] x, input logic [4:0] n);
    int rows;
    logic [15:0] a;
    logic [15:0] ah;
    exp_t e;
    rows = (n > 15) ? 15 : int'(n);
    exp_q.delete();
    addr_q.delete();
    for (int r = 0; r < rows; r++) begin
      a  = b + 16'(r) * s;
      ah = a + 16'd1;
      addr_q.push_back(a);
      for (int k = 0; k < 15; k++) begin
        int i;
        i = int'(x) + k;
        e.row[k*8 +: 8] = (i < 16) ? px(a, i, 1'b0)
                                   : px(ah, i - 16, 1'b1);
      end
      e.idx = 4'(r);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] a;
    logic [15:0] ah;
    exp_t e;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (bus.mem_rd_en) begin
        issued++;
        chk("read_expected", addr_q.size() > 0, 1);
        if (addr_q.size() > 0) begin
          a  = addr_q.pop_front();
          ah = a + 16'd1;
          chk("addr_lo", bus.mem_addr_lo, a);
          chk("addr_hi", bus.mem_addr_hi, ah);
        end
      end
      if (prev_stall) begin
        chk("stall_valid", bus.row_valid, 1);
        chk("stall_row", bus.in_row, prev_row);
        chk("stall_idx", bus.row_idx, prev_idx);
      end
      if (bus.row_valid && bus.row_ready) begin
        accepted++;
        chk("row_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("in_row", bus.in_row, e.row);
          chk("row_idx", bus.row_idx, e.idx);
        end
        if (!first_seen) begin
          first_row  = bus.in_row;
          first_seen = 1;
        end
      end
      chk("occupancy", (issued - accepted) <= 2, 1);
      prev_stall = bus.row_valid && !bus.row_ready;
      prev_row   = bus.in_row;
      prev_idx   = bus.row_idx;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, bus.mem_rd_en, 0);
    chk({tag, "_valid"}, bus.row_valid, 0);
    chk({tag, "_in_row"}, bus.in_row, 0);
    chk({tag, "_row_idx"}, bus.row_idx, 0);
    chk({tag, "_addr_lo"}, bus.mem_addr_lo, 0);
    chk({tag, "_addr_hi"}, bus.mem_addr_hi, 0);
  endtask

  // One window; start is high in cycle 0.
  task automatic run(input logic [15:0] b, input logic [15:0] s,
                     input logic [3:0] x, input logic [4:0] n,
                     input int st_lo, input int st_hi,
                     input bit rnd, input int poke, input int rcyc,
                     output int done_cyc, output int first_rd,
                     output int first_val, output int rd_stall);
    int cyc;
    int done_cnt;
    bit busy_seen;
    bit fin;
    cyc = 0; done_cnt = 0; busy_seen = 0; fin = 0;
    done_cyc = -1; first_rd = -1; first_val = -1; rd_stall = 0;
    model(b, s, x, n);
    issued = 0; accepted = 0; first_seen = 0;
    @(posedge clk); #1;
    start = 1; base_addr = b; stride = s;
    x_off = x; num_rows = n;
    bus.row_ready = rnd ? ($urandom_range(0, 9) < 7)
                        : !(0 >= st_lo && 0 <= st_hi);
    while (!fin) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (busy) busy_seen = 1;
      if (bus.mem_rd_en && first_rd < 0) first_rd = cyc;
      if (bus.row_valid && first_val < 0) first_val = cyc;
      if (bus.mem_rd_en && cyc > st_lo && cyc <= st_hi)
        rd_stall++;
      if (rcyc >= 0 && cyc == rcyc + 1) check_zero("after_reset");
      if (rcyc >= 0 && cyc == rcyc + 3) fin = 1;
      if (rcyc < 0 && done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("busy_after_done", busy, 0);
        chk("done_width", done, 0);
        fin = 1;
      end
      if (!fin && cyc >= 400) begin
        chk("run_timeout", done_cyc >= 0, 1);
        fin = 1;
      end
      @(posedge clk); #1;
      cyc++;
      start = (cyc == poke);
      if (cyc == poke) begin
        base_addr = 16'($urandom); stride = 16'($urandom);
        x_off = 4'($urandom); num_rows = 5'($urandom);
      end
      rst = (rcyc >= 0 && cyc == rcyc);
      if (rcyc >= 0 && cyc == rcyc + 1) begin
        exp_q.delete();
        addr_q.delete();
      end
      bus.row_ready = rnd ? ($urandom_range(0, 9) < 7)
                          : !(cyc >= st_lo && cyc <= st_hi);
    end
    if (rcyc >= 0) begin
      chk("no_done_on_reset", done_cnt, 0);
    end else begin
      chk("done_count", done_cnt, 1);
      chk("rows_left", exp_q.size(), 0);
      chk("reads_left", addr_q.size(), 0);
      chk("busy_seen", busy_seen, n != 0);
    end
    start = 0;
  endtask

  initial begin
    int d, fr, fv, rs;
    seed = $urandom;
    rst = 1; start = 0; base_addr = 0; stride = 0;
    x_off = 0; num_rows = 0; bus.row_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 0;

    run(16'h0100, 16'd4, 4'd0, 5'd15, -1, -1, 0, -1, -1,
        d, fr, fv, rs);
    chk("aligned_first_rd", fr, 1);
    chk("aligned_first_valid", fv, 3);
    chk("aligned_done_cycle", d, 18);

    ramp = 1;
    run(16'h0200, 16'd2, 4'd9, 5'd4, -1, -1, 0, -1, -1,
        d, fr, fv, rs);
    chk("unaligned_row0", first_row,
        120'h17161514131211100F0E0D0C0B0A09);
    ramp = 0;

    run(16'h1234, 16'h0040, 4'd5, 5'd15, 4, 10, 0, -1, -1,
        d, fr, fv, rs);
    chk("stall_reads", rs, 0);

    run(16'h0300, 16'd1, 4'd0, 5'd0, -1, -1, 0, -1, -1,
        d, fr, fv, rs);
    chk("zero_done_cycle", d, 1);
    chk("zero_no_read", fr, -1);

    run(16'h0400, 16'd3, 4'd2, 5'd10, -1, -1, 0, 5, -1,
        d, fr, fv, rs);

    run(16'hFFFE, 16'd1, 4'($urandom), 5'd3, -1, -1, 0, -1, -1,
        d, fr, fv, rs);

    run(16'($urandom), 16'($urandom), 4'($urandom), 5'd20,
        -1, -1, 0, -1, -1, d, fr, fv, rs);

    run(16'h0500, 16'd2, 4'd3, 5'd15, -1, -1, 0, -1, 8,
        d, fr, fv, rs);
    run(16'h0600, 16'd5, 4'd7, 5'd6, -1, -1, 0, -1, -1,
        d, fr, fv, rs);
    chk("post_reset_first_valid", fv, 3);

    for (int t = 0; t < 6; t++) begin
      run(16'($urandom), 16'($urandom), 4'($urandom),
          5'($urandom_range(1, 15)), -1, -1, 1, -1, -1,
          d, fr, fv, rs);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
